// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan-code constants, receiver FSM states and a
// parity helper. The game master controller imports the same constants.
package ps2_pkg;

    localparam logic [7:0] S_KEY        = 8'h1B;
    localparam logic [7:0] P_KEY        = 8'h4D;
    localparam logic [7:0] R_KEY        = 8'h2D;
    localparam logic [7:0] ESC_KEY      = 8'h76;
    localparam logic [7:0] UP_KEY       = 8'h75;
    localparam logic [7:0] DOWN_KEY     = 8'h72;
    localparam logic [7:0] LEFT_KEY     = 8'h6B;
    localparam logic [7:0] RIGHT_KEY    = 8'h74;
    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Keyboard-facing lines and decoded key outputs of the PS/2 receiver.
// master: the receiver itself. slave: the keyboard model / key consumer side.
interface ps2_keyboard_rx_if;

    logic       ps2Clk;
    logic       ps2Data;
    logic [7:0] keycode;
    logic       newKeyStrobe;
    logic       keyBreak;
    logic       keyExtended;
    logic       frameError;

    modport master (
        input  ps2Clk,
        input  ps2Data,
        output keycode,
        output newKeyStrobe,
        output keyBreak,
        output keyExtended,
        output frameError
    );

    modport slave (
        output ps2Clk,
        output ps2Data,
        input  keycode,
        input  newKeyStrobe,
        input  keyBreak,
        input  keyExtended,
        input  frameError
    );

endinterface

// File: rtl/ps2_input_filter.sv
// Synchronises the raw PS/2 lines, deglitches the clock and emits a one-cycle
// pulse on each filtered falling edge together with the data sampled in that cycle.
module ps2_input_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk100MHz,
    input  logic reset,
    input  logic ps2Clk,
    input  logic ps2Data,
    output logic fallEdge,
    output logic dataSample
);

    localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

    logic [1:0]      clk_sync_q, clk_sync_d;
    logic [1:0]      data_sync_q, data_sync_d;
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fall_q, fall_d;
    logic            sample_q, sample_d;

    // Next state: synchroniser shift, run-length filter and edge detection.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2Clk};
        data_sync_d = {data_sync_q[0], ps2Data};
        filt_d      = filt_q;
        cnt_d       = '0;
        // Count consecutive samples disagreeing with the filtered level.
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        fall_d   = filt_q & ~filt_d;
        sample_d = data_sync_q[1];
    end

    // State registers; lines idle high.
    always_ff @(posedge clk100MHz) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
            sample_q    <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            fall_q      <= fall_d;
            sample_q    <= sample_d;
        end
    end

    assign fallEdge   = fall_q;
    assign dataSample = sample_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserialises device-to-host frames, interprets the
// F0 (break) and E0 (extended) prefixes and presents the held key as a level.
// Optional frame watchdog enabled by defining PS2_WATCHDOG_EN.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input logic              clk100MHz,
    input logic              reset,
    ps2_keyboard_rx_if.master bus
);

    logic fall_edge;
    logic data_sample;

    ps2_input_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk100MHz (clk100MHz),
        .reset     (reset),
        .ps2Clk    (bus.ps2Clk),
        .ps2Data   (bus.ps2Data),
        .fallEdge  (fall_edge),
        .dataSample(data_sample)
    );

    ps2_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic [7:0] keycode_q, keycode_d;
    logic       strobe_q, strobe_d;
    logic       key_break_q, key_break_d;
    logic       key_ext_q, key_ext_d;
    logic       err_q, err_d;

`ifdef PS2_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WdW-1:0] wd_q, wd_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next state: frame FSM advanced on filtered falling edges, byte decode on STOP.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        keycode_d   = keycode_q;
        strobe_d    = 1'b0;
        key_break_d = key_break_q;
        key_ext_d   = key_ext_q;
        err_d       = 1'b0;

        if (fall_edge) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_sample) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    // LSB first: shift right, newest bit enters at the top.
                    shift_d   = {data_sample, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = data_sample;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_sample && odd_parity_ok(shift_q, parity_q)) begin
                        if (shift_q == BREAK_PREFIX) begin
                            brk_d = 1'b1;
                        end else if (shift_q == EXT_PREFIX) begin
                            ext_d = 1'b1;
                        end else begin
                            strobe_d    = 1'b1;
                            key_break_d = brk_q;
                            key_ext_d   = ext_q;
                            if (!brk_q) begin
                                keycode_d = shift_q;
                            end else if (shift_q == keycode_q) begin
                                // Only releasing the held key clears the level.
                                keycode_d = 8'h00;
                            end
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef PS2_WATCHDOG_EN
        // Abort a frame whose clock stalls; edges restart the count.
        wd_d = '0;
        if (state_q != IDLE && !fall_edge) begin
            if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                err_d   = 1'b1;
                brk_d   = 1'b0;
                ext_d   = 1'b0;
            end else begin
                wd_d = wd_q + WdW'(1);
            end
        end
`endif
    end

    // Registered FSM state and outputs.
    always_ff @(posedge clk100MHz) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            keycode_q   <= 8'h00;
            strobe_q    <= 1'b0;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
            err_q       <= 1'b0;
`ifdef PS2_WATCHDOG_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            keycode_q   <= keycode_d;
            strobe_q    <= strobe_d;
            key_break_q <= key_break_d;
            key_ext_q   <= key_ext_d;
            err_q       <= err_d;
`ifdef PS2_WATCHDOG_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign bus.keycode      = keycode_q;
    assign bus.newKeyStrobe = strobe_q;
    assign bus.keyBreak     = key_break_q;
    assign bus.keyExtended  = key_ext_q;
    assign bus.frameError   = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Randomised bench for the PS/2 receiver: a keyboard driver feeds frames, a
// key-event model queues expected events, a monitor compares each DUT event.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    logic clk100MHz = 1'b0;
    logic reset     = 1'b1;

    ps2_keyboard_rx_if bus ();

    ps2_keyboard_rx #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(20000)
    ) dut (
        .clk100MHz(clk100MHz),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk100MHz = ~clk100MHz;

    typedef struct {
        bit         is_err;
        logic [7:0] key;
        bit         brk;
        bit         ext;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_key;
    bit         m_brk;
    bit         m_ext;
    logic [7:0] pool[10] = '{8'h1B, 8'h4D, 8'h2D, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74,
                             8'hF0, 8'hE0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Key-event model: what a keyboard byte stream means to the game.
    task automatic model_byte(input logic [7:0] b, input bit good);
        exp_t e;
        if (!good) begin
            m_brk = 0;
            m_ext = 0;
            e = '{is_err: 1, key: m_key, brk: 0, ext: 0};
            exp_q.push_back(e);
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else begin
            if (!m_brk) m_key = b;
            else if (b == m_key) m_key = 8'h00;
            e = '{is_err: 0, key: m_key, brk: m_brk, ext: m_ext};
            exp_q.push_back(e);
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    // Drive the first nbits of a frame; optional 5-cycle low glitches in the data bits.
    task automatic drive_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                               input bit glitch, input int nbits);
        logic [10:0] f;
        int half;
        f    = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        half = $urandom_range(25, 40);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2Data = f[i];
            repeat (half) @(posedge clk100MHz);
            bus.ps2Clk = 1'b0;
            repeat (half) @(posedge clk100MHz);
            bus.ps2Clk = 1'b1;
            if (glitch && i >= 1 && i <= 8) begin
                repeat (15) @(posedge clk100MHz);
                bus.ps2Clk = 1'b0;
                repeat (5) @(posedge clk100MHz);
                bus.ps2Clk = 1'b1;
            end
        end
        bus.ps2Data = 1'b1;
        repeat (30) @(posedge clk100MHz);
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                        input bit glitch);
        model_byte(b, !bad_par && !bad_stop);
        drive_frame(b, bad_par, bad_stop, glitch, 11);
    endtask

    // Monitor: every strobe or error must match the next queued expectation.
    always @(negedge clk100MHz) begin
        if (!reset && (bus.newKeyStrobe || bus.frameError)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got strobe=%0b err=%0b key=%0h, expected none",
                         bus.newKeyStrobe, bus.frameError, bus.keycode);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", {30'd0, bus.newKeyStrobe, bus.frameError},
                      mon_e.is_err ? 32'd1 : 32'd2);
                check("keycode", {24'd0, bus.keycode}, {24'd0, mon_e.key});
                if (!mon_e.is_err) begin
                    check("keyBreak", {31'd0, bus.keyBreak}, {31'd0, mon_e.brk});
                    check("keyExtended", {31'd0, bus.keyExtended}, {31'd0, mon_e.ext});
                end
            end
        end
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ps2Clk  = 1'b1;
        bus.ps2Data = 1'b1;
        m_key = 8'h00;
        m_brk = 0;
        m_ext = 0;
        repeat (5) @(posedge clk100MHz);
        reset = 1'b0;
        @(negedge clk100MHz);
        check("rst_keycode", {24'd0, bus.keycode}, 32'd0);
        check("rst_strobe", {31'd0, bus.newKeyStrobe}, 32'd0);
        check("rst_break", {31'd0, bus.keyBreak}, 32'd0);
        check("rst_ext", {31'd0, bus.keyExtended}, 32'd0);
        check("rst_err", {31'd0, bus.frameError}, 32'd0);

        // Directed sequences.
        send(S_KEY, 0, 0, 0);
        send(BREAK_PREFIX, 0, 0, 0);
        send(S_KEY, 0, 0, 0);
        send(EXT_PREFIX, 0, 0, 0);
        send(UP_KEY, 0, 0, 0);
        send(EXT_PREFIX, 0, 0, 0);
        send(BREAK_PREFIX, 0, 0, 0);
        send(UP_KEY, 0, 0, 0);
        send(RIGHT_KEY, 1, 0, 0);
        send(LEFT_KEY, 0, 0, 0);
        send(LEFT_KEY, 0, 0, 0);
        send(BREAK_PREFIX, 0, 0, 0);
        send(ESC_KEY, 0, 0, 0);
        send(P_KEY, 0, 0, 1);
        send(EXT_PREFIX, 0, 1, 0);
        send(DOWN_KEY, 0, 0, 0);
        @(negedge clk100MHz);
        check("held_keycode", {24'd0, bus.keycode}, {24'd0, m_key});

        // Reset in the middle of a frame: no event, state cleared.
        drive_frame(R_KEY, 0, 0, 0, 5);
        @(posedge clk100MHz);
        reset = 1'b1;
        repeat (3) @(posedge clk100MHz);
        reset = 1'b0;
        m_key = 8'h00;
        m_brk = 0;
        m_ext = 0;
        @(negedge clk100MHz);
        check("midframe_rst_keycode", {24'd0, bus.keycode}, 32'd0);
        send(R_KEY, 0, 0, 0);

        // Random byte stream.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
            send(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 4) == 0);
        end

`ifdef PS2_WATCHDOG_EN
        // Stalled frame: start bit plus four data bits, then silence.
        begin
            exp_t e;
            e = '{is_err: 1, key: m_key, brk: 0, ext: 0};
            exp_q.push_back(e);
            m_brk = 0;
            m_ext = 0;
        end
        drive_frame(R_KEY, 0, 0, 0, 5);
        repeat (20100) @(posedge clk100MHz);
        check("watchdog_fired", exp_q.size(), 32'd0);
        send(R_KEY, 0, 0, 0);
`endif

        repeat (50) @(posedge clk100MHz);
        @(negedge clk100MHz);
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_keycode", {24'd0, bus.keycode}, {24'd0, m_key});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
